oflow_history_line_feeder: RTL and testbench

// - Downstream consumer of the MEM buffer wrapper. Requests history lines via read_new_line,

---
 rtl/oflow_history_line_feeder.sv | 191 +++++++++++++++++++
 tb/tb_oflow_history_line_feeder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oflow_history_line_feeder.sv
// History line feeder: requests lines from the MEM buffer wrapper, assembles bbox pairs
// into one of two ping-pong slots and presents completed lines with valid/ready.
module oflow_history_line_feeder #(
  parameter int DATA_WIDTH = 64,
  parameter int LINE_PAIRS = 4,
  parameter int HIST_W     = 3
) (
  input  logic                               clk,
  input  logic                               reset_N,
  input  logic                               start,
  input  logic [HIST_W-1:0]                  num_of_history_frames,
  input  logic                               mem_valid,
  input  logic [DATA_WIDTH-1:0]              mem_data_0,
  input  logic [DATA_WIDTH-1:0]              mem_data_1,
  output logic                               read_new_line,
  input  logic                               line_ready,
  output logic                               line_valid,
  output logic [2*LINE_PAIRS*DATA_WIDTH-1:0] line_data,
  output logic [HIST_W-1:0]                  line_hist_idx,
  output logic                               line_last,
  output logic                               busy,
  output logic                               done,
  output logic                               overflow_err
);

  localparam int LINE_W = 2 * LINE_PAIRS * DATA_WIDTH;
  localparam int PAIR_W = 2 * DATA_WIDTH;
  localparam int PC_W   = (LINE_PAIRS > 1) ? $clog2(LINE_PAIRS) : 1;
  localparam int CNT_W  = HIST_W + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_FILL      = 3'd2,
    S_WAIT_SLOT = 3'd3,
    S_DRAIN     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [PC_W-1:0]    pair_cnt_q, pair_cnt_d;
  logic               ws_q, ws_d;
  logic               rs_q, rs_d;
  logic [1:0]         full_q, full_d;
  logic [1:0]         last_q, last_d;
  logic [HIST_W-1:0]  hist_q [2];
  logic [HIST_W-1:0]  hist_d [2];
  logic [LINE_W-1:0]  slot_q [2];
  logic [LINE_W-1:0]  slot_d [2];
  logic               ovf_q, ovf_d;

  logic               accept_s;
  logic               start_ok_s;
  logic               final_s;
  logic               nxt_free_s;
  logic               ws_n_s;

  // Next-state logic for the write FSM, slot bookkeeping and the read side
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    req_cnt_d  = req_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    pair_cnt_d = pair_cnt_q;
    ws_d       = ws_q;
    rs_d       = rs_q;
    full_d     = full_q;
    last_d     = last_q;
    hist_d     = hist_q;
    slot_d     = slot_q;

    ws_n_s     = ~ws_q;
    accept_s   = full_q[rs_q] & line_ready;
    start_ok_s = (state_q == S_IDLE) & start;
    final_s    = (state_q == S_FILL) & mem_valid & (pair_cnt_q == PC_W'(LINE_PAIRS - 1));
    // A slot released this cycle already counts as free for the FILL exit decision
    nxt_free_s = ~full_q[ws_n_s] | (accept_s & (rs_q == ws_n_s));
    ovf_d      = (start_ok_s ? 1'b0 : ovf_q) | (mem_valid & (state_q != S_FILL));

    if (accept_s) begin
      full_d[rs_q] = 1'b0;
      rs_d         = ~rs_q;
      acc_cnt_d    = acc_cnt_q + CNT_W'(1);
    end else begin
      rs_d = rs_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d       = {1'b0, num_of_history_frames};
          req_cnt_d = CNT_W'(0);
          acc_cnt_d = CNT_W'(0);
          state_d   = (num_of_history_frames == HIST_W'(0)) ? S_DRAIN : S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        pair_cnt_d = PC_W'(0);
        state_d    = S_FILL;
      end
      S_FILL: begin
        if (mem_valid) begin
          slot_d[ws_q][pair_cnt_q*PAIR_W +: PAIR_W] = {mem_data_1, mem_data_0};
          if (final_s) begin
            pair_cnt_d     = PC_W'(0);
            full_d[ws_q]   = 1'b1;
            hist_d[ws_q]   = req_cnt_q[HIST_W-1:0];
            last_d[ws_q]   = (req_cnt_q == (n_q - CNT_W'(1)));
            req_cnt_d      = req_cnt_q + CNT_W'(1);
            ws_d           = ws_n_s;
            if ((req_cnt_q + CNT_W'(1)) == n_q) begin
              state_d = S_DRAIN;
            end else if (nxt_free_s) begin
              state_d = S_REQ;
            end else begin
              state_d = S_WAIT_SLOT;
            end
          end else begin
            pair_cnt_d = pair_cnt_q + PC_W'(1);
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_WAIT_SLOT: begin
        if (!full_q[ws_q]) begin
          state_d = S_REQ;
        end else begin
          state_d = S_WAIT_SLOT;
        end
      end
      S_DRAIN: begin
        if ((full_q == 2'b00) && (acc_cnt_q == n_q)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset_N) begin
      state_q    <= S_IDLE;
      n_q        <= CNT_W'(0);
      req_cnt_q  <= CNT_W'(0);
      acc_cnt_q  <= CNT_W'(0);
      pair_cnt_q <= PC_W'(0);
      ws_q       <= 1'b0;
      rs_q       <= 1'b0;
      full_q     <= 2'b00;
      last_q     <= 2'b00;
      hist_q[0]  <= HIST_W'(0);
      hist_q[1]  <= HIST_W'(0);
      slot_q[0]  <= LINE_W'(0);
      slot_q[1]  <= LINE_W'(0);
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      req_cnt_q  <= req_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      pair_cnt_q <= pair_cnt_d;
      ws_q       <= ws_d;
      rs_q       <= rs_d;
      full_q     <= full_d;
      last_q     <= last_d;
      hist_q     <= hist_d;
      slot_q     <= slot_d;
      ovf_q      <= ovf_d;
    end
  end

  assign read_new_line = (state_q == S_REQ);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DRAIN) & (full_q == 2'b00) & (acc_cnt_q == n_q);
  assign line_valid    = full_q[rs_q];
  assign line_data     = slot_q[rs_q];
  assign line_hist_idx = hist_q[rs_q];
  assign line_last     = last_q[rs_q];
  assign overflow_err  = ovf_q;

endmodule

// File: tb/tb_oflow_history_line_feeder.sv
// Bench for oflow_history_line_feeder: random MEM-side/consumer behaviour checked against a
// queue-based model of the lines a frame must produce, plus directed corner sequences.
module tb_oflow_history_line_feeder;
  localparam int DW = 64;
  localparam int LP = 4;
  localparam int HW = 3;
  localparam int LW = 2 * LP * DW;

  logic          clk = 1'b0;
  logic          reset_N = 1'b1;
  logic          start = 1'b0;
  logic [HW-1:0] num = '0;
  logic          mem_valid = 1'b0;
  logic [DW-1:0] d0 = '0;
  logic [DW-1:0] d1 = '0;
  logic          line_ready = 1'b0;
  logic          read_new_line, line_valid, line_last, busy, done, overflow_err;
  logic [LW-1:0] line_data;
  logic [HW-1:0] line_hist_idx;

  oflow_history_line_feeder #(.DATA_WIDTH(DW), .LINE_PAIRS(LP), .HIST_W(HW)) dut (
    .clk(clk), .reset_N(reset_N), .start(start), .num_of_history_frames(num),
    .mem_valid(mem_valid), .mem_data_0(d0), .mem_data_1(d1), .read_new_line(read_new_line),
    .line_ready(line_ready), .line_valid(line_valid), .line_data(line_data),
    .line_hist_idx(line_hist_idx), .line_last(line_last), .busy(busy), .done(done),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0] data;
    int            idx;
    logic          last;
  } line_t;

  typedef struct {
    int n;
    int gap_pct;
    int ready_pct;
    int exp_reads;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // model of the expected frame
  int m_n, m_built, m_acc, m_rnl, pend, pair_idx;
  logic [LW-1:0] cur_line;
  line_t expq[$];
  bit sent_pair, done_exp, done_seen, prev_stall, force_mv, start_req;
  logic [LW-1:0] prev_data;
  logic [HW-1:0] prev_idx;
  int gap_pct = 0, ready_pct = 100, start_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_n = 0; m_built = 0; m_acc = 0; m_rnl = 0; pend = 0; pair_idx = 0;
    cur_line = '0; expq.delete(); done_exp = 0; prev_stall = 0;
  endtask

  task automatic observe();
    line_t e;
    if (reset_N) begin
      model_clear();
      return;
    end
    chk("done", done, done_exp);
    if (done) done_seen = 1;
    done_exp = 0;
    if (prev_stall) begin
      chk("valid_held", line_valid, 1);
      chkw("stable_data", line_data, prev_data);
      chk("stable_idx", line_hist_idx, prev_idx);
    end
    if (start && !busy) begin
      m_n = num; m_built = 0; m_acc = 0; m_rnl = 0; expq.delete();
      if (num == 0) done_exp = 1;
    end
    if (read_new_line) begin
      m_rnl++;
      chk("rnl_budget", m_rnl <= m_n, 1);
      chk("rnl_slot_free", (m_built - m_acc) <= 1, 1);
      pend = LP; pair_idx = 0;
    end
    if (line_valid && line_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_line", 1, 0);
      end else begin
        e = expq.pop_front();
        chkw("line_data", line_data, e.data);
        chk("line_idx", line_hist_idx, e.idx);
        chk("line_last", line_last, e.last);
        m_acc++;
        if (e.last) done_exp = 1;
      end
    end
    if (sent_pair) begin
      cur_line[pair_idx*2*DW +: 2*DW] = {d1, d0};
      pair_idx++;
      if (pair_idx == LP) begin
        e.data = cur_line; e.idx = m_built; e.last = (m_built == m_n - 1);
        expq.push_back(e);
        m_built++;
      end
    end
    prev_stall = line_valid && !line_ready;
    prev_data = line_data;
    prev_idx = line_hist_idx;
  endtask

  task automatic plan();
    start = start_req; num = HW'(start_n); start_req = 0;
    if (force_mv) begin
      mem_valid = 1; force_mv = 0; sent_pair = 0;
    end else if (pend > 0 && $urandom_range(99) >= gap_pct) begin
      mem_valid = 1; d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
      pend--; sent_pair = 1;
    end else begin
      mem_valid = 0; sent_pair = 0;
    end
    line_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    plan();
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!done_seen && t < 3000) begin tick(); t++; end
    if (!done_seen) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic run_frame(input int n, input int gp, input int rp, input int exp_reads);
    gap_pct = gp; ready_pct = rp; start_req = 1; start_n = n; done_seen = 0;
    tick();
    wait_done("frame");
    chk("frame_reads", m_rnl, exp_reads);
    chk("frame_lines", m_acc, exp_reads);
    tick();
    chk("frame_idle", busy, 0);
    chk("frame_no_ovf", overflow_err, 0);
  endtask

  vec_t tbl[6];

  initial begin
    int t;
    tbl[0] = '{n: 3, gap_pct: 0,  ready_pct: 100, exp_reads: 3};
    tbl[1] = '{n: 1, gap_pct: 50, ready_pct: 50,  exp_reads: 1};
    tbl[2] = '{n: 7, gap_pct: 30, ready_pct: 40,  exp_reads: 7};
    tbl[3] = '{n: 0, gap_pct: 0,  ready_pct: 100, exp_reads: 0};
    tbl[4] = '{n: 5, gap_pct: 0,  ready_pct: 10,  exp_reads: 5};
    tbl[5] = '{n: 2, gap_pct: 70, ready_pct: 100, exp_reads: 2};
    model_clear();

    // reset with mem_valid high
    reset_N = 1; mem_valid = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_rnl", read_new_line, 0);
    chk("rst_valid", line_valid, 0);
    chkw("rst_data", line_data, '0);
    chk("rst_idx", line_hist_idx, 0);
    chk("rst_last", line_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow_err, 0);
    reset_N = 0; mem_valid = 0;
    tick();
    chk("post_rst_ovf", overflow_err, 0);

    for (int i = 0; i < 6; i++) run_frame(tbl[i].n, tbl[i].gap_pct, tbl[i].ready_pct, tbl[i].exp_reads);

    // N=0: one busy cycle with done, no requests
    ready_pct = 100; start_req = 1; start_n = 0; done_seen = 0;
    tick(); tick();
    chk("n0_busy", busy, 1);
    chk("n0_done", done, 1);
    tick();
    chk("n0_busy_end", busy, 0);
    chk("n0_reads", m_rnl, 0);

    // mem_valid while idle sets sticky overflow; next start clears it
    force_mv = 1;
    tick(); tick();
    chk("ovf_set", overflow_err, 1);
    tick(); tick();
    chk("ovf_sticky", overflow_err, 1);
    run_frame(1, 0, 100, 1);

    // N=2 with consumer stalled until both lines are captured
    gap_pct = 0; ready_pct = 0; start_req = 1; start_n = 2; done_seen = 0;
    t = 0;
    while (m_built < 2 && t < 200) begin tick(); t++; end
    chk("stall_built", m_built, 2);
    for (int i = 0; i < 5; i++) tick();
    chk("stall_busy", busy, 1);
    chk("stall_valid", line_valid, 1);
    chk("stall_idx0", line_hist_idx, 0);
    chk("stall_no_req", read_new_line, 0);
    chk("stall_reads", m_rnl, 2);
    ready_pct = 100;
    wait_done("stall");
    chk("stall_lines", m_acc, 2);
    tick();
    chk("stall_idle", busy, 0);

    // reset in the middle of FILL, after two pairs of the first line
    gap_pct = 0; ready_pct = 100; start_req = 1; start_n = 3; done_seen = 0;
    t = 0;
    while (!(pend > 0 && pair_idx == 2) && t < 200) begin tick(); t++; end
    chk("midfill_reached", pair_idx, 2);
    reset_N = 1; mem_valid = 0; sent_pair = 0; pend = 0;
    tick();
    reset_N = 0;
    chk("midfill_valid", line_valid, 0);
    chk("midfill_busy", busy, 0);
    run_frame(2, 20, 60, 2);

    // randomized frames
    for (int i = 0; i < 8; i++) begin
      int n;
      n = $urandom_range(7);
      run_frame(n, $urandom_range(60), $urandom_range(100, 20), n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
